// File: rtl/stream_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin stream arbiter.
// Both the top level and its priority-search sub-module import this package.
package stream_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int N_PORTS = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  // One-hot decode of a port index, used to steer in_ready to the granted port.
  function automatic logic [N_PORTS-1:0] port_onehot(input logic [IDX_W-1:0] idx);
    logic [N_PORTS-1:0] vec;
    vec      = {N_PORTS{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Rotating-priority search: grants the first requester after ptr, wrapping modulo 4.
// Purely combinational; the caller registers the result.
module rr_pick
  import stream_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       gnt_any
);

  logic [2:0] shift_s;
  logic [7:0] dbl_s;
  logic [3:0] rot_s;
  logic [1:0] off_s;

  // Rotate requests so that bit 0 is the port right after ptr.
  always_comb begin
    shift_s = {1'b0, ptr} + 3'd1;
    dbl_s   = {req, req} >> shift_s;
    rot_s   = dbl_s[3:0];
  end

  // Lowest set bit of the rotated vector is the winner's distance from ptr+1.
  always_comb begin
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
  end

  // Translate the offset back to an absolute port index.
  always_comb begin
    gnt_idx = ptr + 2'd1 + off_s;
    gnt_any = |req;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Four-input packet-level round-robin stream arbiter with a registered output stage.
// A grant is held for a whole packet; one idle arbitration cycle separates packets.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int DATA_W  = stream_arb_pkg::DATA_W,
  parameter int N_PORTS = stream_arb_pkg::N_PORTS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS*DATA_W-1:0] in_data,
  input  logic [N_PORTS-1:0]        in_valid,
  input  logic [N_PORTS-1:0]        in_last,
  output logic [N_PORTS-1:0]        in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [1:0]                out_src,
  input  logic                      out_ready,
  output logic                      busy
);

  arb_state_e        state_r;
  logic [1:0]        ptr_r;
  logic [1:0]        gnt_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [1:0]        out_src_r;

  logic [1:0]        pick_idx_s;
  logic              pick_any_s;
  logic              beat_ok_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              in_xfer_s;

  rr_pick u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_r),
    .gnt_idx (pick_idx_s),
    .gnt_any (pick_any_s)
  );

  // Granted-port selection and the input-side transfer condition.
  always_comb begin
    beat_ok_s   = !out_valid_r || out_ready;
    sel_valid_s = in_valid[gnt_r];
    sel_last_s  = in_last[gnt_r];
    sel_data_s  = in_data[gnt_r*DATA_W +: DATA_W];
    in_xfer_s   = (state_r == ST_LOCK) && beat_ok_s && sel_valid_s;
  end

  // Only the locked port sees ready, and only when the output register can take a beat.
  always_comb begin
    in_ready = {N_PORTS{1'b0}};
    if ((state_r == ST_LOCK) && beat_ok_s) begin
      in_ready = port_onehot(gnt_r);
    end else begin
      in_ready = {N_PORTS{1'b0}};
    end
  end

  // Arbitration FSM: grant in IDLE, hold through the packet, advance ptr on the last beat.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd3;
      gnt_r   <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            gnt_r   <= pick_idx_s;
            state_r <= ST_LOCK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (in_xfer_s && sel_last_s) begin
            ptr_r   <= gnt_r;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_LOCK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: load on input transfer, drain when downstream accepts with nothing new.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_src_r   <= 2'd0;
    end else if (in_xfer_s) begin
      out_data_r  <= sel_data_s;
      out_valid_r <= 1'b1;
      out_last_r  <= sel_last_s;
      out_src_r   <= gnt_r;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_src   = out_src_r;
  assign busy      = (state_r == ST_LOCK);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Randomized and directed bench for stream_rr_arbiter against a packet-level reference model.
// The model tracks locked port, last grant and the pending output beat as plain integers.
module tb_stream_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        busy;

  stream_rr_arbiter #(.DATA_W(8), .N_PORTS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-port source queues
  logic [7:0] pq_data [4][$];
  bit         pq_last [4][$];

  // Observed output transfers (from the DUT)
  logic [7:0] obs_d [$];
  int         obs_s [$];
  bit         obs_l [$];
  int         obs_c [$];

  // Reference model
  int         m_lock;
  int         m_ptr;
  bit         m_ov;
  bit         m_ol;
  logic [7:0] m_od;
  int         m_os;

  int valid_pct = 100;
  int rdy_pct   = 100;
  int rdy_force = 1;
  int cyc       = 0;
  int tot_in    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_pkt(input int port, input logic [7:0] first, input int len);
    for (int k = 0; k < len; k++) begin
      pq_data[port].push_back(first + 8'(k));
      pq_last[port].push_back(k == len - 1);
    end
  endtask

  task automatic flush_q();
    for (int i = 0; i < 4; i++) begin
      pq_data[i].delete();
      pq_last[i].delete();
    end
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_s.delete(); obs_l.delete(); obs_c.delete();
  endtask

  // One clock cycle: drive at negedge, compare, advance the model at posedge.
  task automatic step();
    logic [3:0] exp_rdy;
    bit in_x, out_x;
    for (int i = 0; i < 4; i++) begin
      if (pq_data[i].size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid[i]        = 1'b1;
        in_data[i*8 +: 8]  = pq_data[i][0];
        in_last[i]         = pq_last[i][0];
      end else begin
        in_valid[i]        = 1'b0;
        in_data[i*8 +: 8]  = 8'($urandom);
        in_last[i]         = 1'($urandom);
      end
    end
    if (rdy_force >= 0) out_ready = rdy_force[0];
    else                out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    exp_rdy = 4'b0000;
    if (m_lock >= 0 && (!m_ov || out_ready)) exp_rdy[m_lock] = 1'b1;
    if (reset) begin
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_last", 32'(out_last), 32'(m_ol));
      check("out_src", 32'(out_src), 32'(m_os));
      check("busy", 32'(busy), 32'(m_lock >= 0));
    end
    in_x  = reset && (m_lock >= 0) && in_valid[m_lock] && exp_rdy[m_lock];
    out_x = reset && m_ov && out_ready;
    if (reset && out_valid && out_ready) begin
      obs_d.push_back(out_data); obs_s.push_back(int'(out_src));
      obs_l.push_back(out_last); obs_c.push_back(cyc);
    end
    @(posedge clk);
    if (!reset) begin
      m_lock = -1; m_ptr = 3; m_ov = 1'b0; m_ol = 1'b0; m_od = 8'h00; m_os = 0;
    end else begin
      if (in_x) begin
        m_ov = 1'b1;
        m_od = pq_data[m_lock][0];
        m_ol = pq_last[m_lock][0];
        m_os = m_lock;
        void'(pq_data[m_lock].pop_front());
        void'(pq_last[m_lock].pop_front());
      end else if (out_x) begin
        m_ov = 1'b0;
      end
      if (m_lock < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_lock < 0 && in_valid[(m_ptr + k) % 4]) m_lock = (m_ptr + k) % 4;
        end
      end else if (in_x && m_ol) begin
        m_ptr  = m_lock;
        m_lock = -1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush_q();
    run(2);
    reset = 1'b1;
    clear_obs();
  endtask

  initial begin
    reset = 1'b0; in_data = 32'h0; in_valid = 4'h0; in_last = 4'h0; out_ready = 1'b0;
    m_lock = -1; m_ptr = 3; m_ov = 1'b0; m_ol = 1'b0; m_od = 8'h00; m_os = 0;
    @(negedge clk);

    // Two 3-beat packets on ports 0 and 2, full-rate sink
    do_reset();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    push_pkt(0, 8'h11, 3);
    push_pkt(2, 8'h21, 3);
    run(14);
    check("t1_count", obs_d.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_d.size()) begin
        check("t1_data", 32'(obs_d[i]), (i < 3) ? 32'h11 + 32'(i) : 32'h21 + 32'(i - 3));
        check("t1_src", 32'(obs_s[i]), (i < 3) ? 32'd0 : 32'd2);
        check("t1_last", 32'(obs_l[i]), 32'(i == 2 || i == 5));
      end
    end
    if (obs_c.size() >= 4) begin
      check("t1_rate", 32'(obs_c[1] - obs_c[0]), 32'd1);
      check("t1_gap", 32'(obs_c[3] - obs_c[2]), 32'd2);
    end

    // All ports continuously offer single-beat packets
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_pkt(i, 8'(i * 16), 1);
      push_pkt(i, 8'(i * 16 + 1), 1);
    end
    run(24);
    check("t2_count", obs_s.size(), 8);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_s.size()) check("t2_src", 32'(obs_s[i]), 32'(i % 4));
    end

    // Downstream stall mid-packet on port 1
    do_reset();
    push_pkt(1, 8'h31, 6);
    run(3);
    rdy_force = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold", 32'(out_data), 32'h32);
      check("t3_ready", 32'(in_ready), 32'd0);
    end
    rdy_force = 1;
    run(12);
    check("t3_count", obs_d.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < obs_d.size()) check("t3_data", 32'(obs_d[i]), 32'h31 + 32'(i));
    end

    // Port 3 requests while port 0 is locked
    do_reset();
    push_pkt(0, 8'h41, 4);
    run(2);
    push_pkt(3, 8'h51, 1);
    run(12);
    check("t4_count", obs_d.size(), 5);
    if (obs_d.size() >= 5) begin
      check("t4_p0_end", 32'(obs_d[3]), 32'h44);
      check("t4_p3_data", 32'(obs_d[4]), 32'h51);
      check("t4_p3_src", 32'(obs_s[4]), 32'd3);
    end

    // Reset during the second beat of a packet; ptr must return to 3
    do_reset();
    push_pkt(1, 8'h61, 2);
    run(8);
    push_pkt(2, 8'h71, 3);
    run(2);
    reset = 1'b0;
    step();
    reset = 1'b1;
    flush_q();
    clear_obs();
    check("t5_ov", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    push_pkt(0, 8'h81, 1);
    push_pkt(2, 8'h91, 1);
    push_pkt(3, 8'hA1, 1);
    run(12);
    check("t5_count", obs_d.size(), 3);
    if (obs_d.size() >= 1) begin
      check("t5_first_src", 32'(obs_s[0]), 32'd0);
      check("t5_first_data", 32'(obs_d[0]), 32'h81);
    end

    // Single-beat packet on port 2
    do_reset();
    push_pkt(2, 8'hC5, 1);
    run(2);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_last", 32'(out_last), 32'd1);
    check("t6_src", 32'(out_src), 32'd2);
    check("t6_data", 32'(out_data), 32'hC5);
    check("t6_idle", 32'(busy), 32'd0);
    run(3);

    // Randomized traffic with random gaps and back-pressure
    do_reset();
    valid_pct = 70; rdy_force = -1; rdy_pct = 60; tot_in = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (pq_data[i].size() == 0 && $urandom_range(3) == 0) begin
          int len;
          len = $urandom_range(5, 1);
          push_pkt(i, 8'($urandom), len);
          tot_in += len;
        end
      end
      step();
    end
    begin
      int guard;
      guard = 0;
      while ((pq_data[0].size() + pq_data[1].size() + pq_data[2].size() + pq_data[3].size() > 0
              || m_ov || m_lock >= 0) && guard < 4000) begin
        step();
        guard++;
      end
      check("drain_timeout", 32'(guard >= 4000), 32'd0);
    end
    check("rand_beats", obs_d.size(), tot_in);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk and reset (reset low = reset), sampled on the rising edge of clk.
REQ-002 SHALL have parameter DATA_W, default 8, meaning bit width of each data beat.
REQ-003 SHALL have parameter N_PORTS, default 4, meaning number of requesting input streams (fixed at 4 in this revision).
REQ-004 SHALL provide these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock
- reset  in  1  sync active-low reset
- in_data  in  N_PORTS*DATA_W  packed input beats; port i occupies bits [i*DATA_W +: DATA_W]
- in_valid  in  N_PORTS  per-port beat valid
- in_last  in  N_PORTS  per-port end-of-packet flag
- in_ready  out  N_PORTS  per-port accept
- out_data  out  DATA_W  registered output beat
- out_valid  out  1  registered output valid
- out_last  out  1  registered output end-of-packet
- out_src  out  2  index of the port that sourced the current output beat
- out_ready  in  1  downstream accept
- busy  out  1  high while a packet is locked

Function
REQ-005 SHALL use a handshake where a beat transfers on any edge with valid=1 and ready=1, on both the input and output sides.
REQ-006 SHALL implement a two-state FSM:
- IDLE -> LOCK when any in_valid is 1; the grant is registered on that edge.
- LOCK -> IDLE on the edge where the granted port's beat with in_last=1 transfers.
REQ-007 SHALL arbitrate round-robin in IDLE: search ports ptr+1, ptr+2, ptr+3, ptr+4 (mod 4) and grant the first with in_valid=1, where ptr is the last granted port.
REQ-008 SHALL update ptr to the granted index only when the packet's last beat transfers.
REQ-009 SHALL hold the grant for the whole packet; no other port is served until the last beat transfers.
REQ-010 SHALL drive in_ready[g] = (state==LOCK) && (!out_valid || out_ready) for granted port g, and in_ready = 0 for every other port and in IDLE.
REQ-011 SHALL load out_data, out_last and out_src with the granted port's values and set out_valid=1 on each input transfer; latency is 1 cycle from input transfer to out_valid.
REQ-012 SHALL clear out_valid when the output beat transfers and no new input transfer occurs on the same edge.
REQ-013 SHALL hold out_data, out_last and out_src stable while out_valid=1 and out_ready=0.
REQ-014 SHALL sustain 1 beat/cycle inside a packet when out_ready is held at 1.
REQ-015 SHALL insert exactly one IDLE arbitration cycle between packets (no same-cycle regrant).
REQ-016 SHALL ignore in_valid changes on non-granted ports during LOCK.
REQ-017 SHALL NOT require in_valid of the granted port to stay high between beats; gaps stall the transfer only.
REQ-018 SHALL drive busy = (state==LOCK).

Reset
REQ-019 SHALL, while reset=0 at a clock edge, drive out_valid=0, out_last=0, out_data=0, out_src=0, busy=0, in_ready=0, state=IDLE and ptr=3, so port 0 has first priority.
REQ-020 SHALL, when reset is asserted mid-packet, discard the remainder of the packet and the registered output beat, with no recovery of partial packets.

Structure
REQ-021 SHALL take DATA_W, N_PORTS and the state encoding (IDLE=0, LOCK=1) from shared package stream_arb_pkg.
REQ-022 SHALL place the rotating priority search in one combinational sub-module, rr_pick, with inputs req[3:0] and ptr[1:0] and outputs gnt_idx[1:0] and gnt_any.

Verification
REQ-023 SHALL check: ports 0 and 2 each present a 3-beat packet (0x11,0x12,0x13 / 0x21,0x22,0x23), out_ready=1 -> output 0x11,0x12,0x13 (src 0), then 0x21,0x22,0x23 (src 2), with one idle cycle between packets.
REQ-024 SHALL check: all 4 ports continuously request 1-beat packets -> out_src sequence 0,1,2,3,0,1.
REQ-025 SHALL check: out_ready=0 for 5 cycles mid-packet on port 1 -> out_data held constant, in_ready[1]=0 after the output register fills, no beat lost or duplicated.
REQ-026 SHALL check: port 3 raises in_valid while port 0's packet is locked -> port 3's data does not appear until after port 0's last beat.
REQ-027 SHALL check: reset=0 asserted during the 2nd beat of a packet -> next cycle out_valid=0, busy=0, and port 0 is granted first afterwards.
REQ-028 SHALL check: a single-beat packet with in_last=1 on port 2 -> out_last=1 and out_src=2 one cycle after transfer, FSM back in IDLE on the same edge.
